// File: rtl/fft_in_commutator.sv
// Input-side frame formatter: serial complex samples in, ping-pong banked frames
// replayed as four parallel lanes (x[k], x[k+N/2], x[k+N/4], x[k+3N/4]) per beat.
module fft_in_commutator #(
  parameter int unsigned NBITS = 10,
  parameter int unsigned N     = 128,
  parameter int unsigned LOG2N = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*NBITS-1:0]   in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*NBITS-1:0]   fftIn0_up,
  output logic [2*NBITS-1:0]   fftIn0_down,
  output logic [2*NBITS-1:0]   fftIn1_up,
  output logic [2*NBITS-1:0]   fftIn1_down,
  output logic                 out_valid,
  output logic                 out_start
);

  localparam int unsigned W  = 2 * NBITS;
  localparam int unsigned KW = LOG2N - 2;
  localparam int unsigned NQ = N / 4;
  localparam logic [LOG2N-1:0] LAST_WP = LOG2N'(N - 1);
  localparam logic [KW-1:0]    LAST_K  = KW'(NQ - 1);

  typedef enum logic [1:0] {
    B_EMPTY    = 2'd0,
    B_FILLING  = 2'd1,
    B_FULL     = 2'd2,
    B_DRAINING = 2'd3
  } bank_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } rd_state_e;

  // Two banks, each split into four quarter-banks so one beat reads four words.
  logic [W-1:0] mem_q [2][4][NQ];

  rd_state_e        state_q, state_d;
  bank_e            bank_q [2];
  bank_e            bank_d [2];
  logic             ws_q, ws_d;
  logic             rd_sel_q, rd_sel_d;
  logic [LOG2N-1:0] wp_q, wp_d;
  logic [KW-1:0]    k_q, k_d;

  logic [W-1:0] lane0_q, lane1_q, lane2_q, lane3_q;
  logic         out_valid_q, out_start_q;

  logic writable_c;
  logic wr_en_c;
  logic oth_sel_c;

  assign writable_c = (bank_q[ws_q] == B_EMPTY) || (bank_q[ws_q] == B_FILLING);
  assign in_ready   = ~rst & writable_c;
  assign wr_en_c    = in_valid & in_ready;
  assign oth_sel_c  = ~rd_sel_q;

  // Sample storage; quarter = top two address bits, offset = the rest.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[ws_q][wp_q[LOG2N-1 -: 2]][wp_q[KW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bank_q[0] <= B_EMPTY;
      bank_q[1] <= B_EMPTY;
      ws_q      <= 1'b0;
      rd_sel_q  <= 1'b0;
      wp_q      <= '0;
      k_q       <= '0;
    end else begin
      state_q   <= state_d;
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      ws_q      <= ws_d;
      rd_sel_q  <= rd_sel_d;
      wp_q      <= wp_d;
      k_q       <= k_d;
    end
  end

  // Write and read sides never touch the same bank in one cycle: writes only
  // hit EMPTY/FILLING banks, reads only FULL/DRAINING ones.
  always_comb begin
    state_d   = state_q;
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    ws_d      = ws_q;
    rd_sel_d  = rd_sel_q;
    wp_d      = wp_q;
    k_d       = k_q;

    if (wr_en_c) begin
      wp_d = wp_q + LOG2N'(1);
      if (wp_q == LAST_WP) begin
        bank_d[ws_q] = B_FULL;
        ws_d         = ~ws_q;
      end else begin
        bank_d[ws_q] = B_FILLING;
      end
    end

    // Banks fill alternately, so the oldest FULL bank is always rd_sel_q.
    case (state_q)
      S_IDLE: begin
        if (bank_q[rd_sel_q] == B_FULL) begin
          state_d          = S_READ;
          k_d              = '0;
          bank_d[rd_sel_q] = B_DRAINING;
        end
      end
      S_READ: begin
        k_d = k_q + KW'(1);
        if (k_q == LAST_K) begin
          bank_d[rd_sel_q] = B_EMPTY;
          rd_sel_d         = oth_sel_c;
          k_d              = '0;
          if (bank_q[oth_sel_c] == B_FULL) begin
            bank_d[oth_sel_c] = B_DRAINING;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered lanes; they hold their last beat while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane0_q     <= '0;
      lane1_q     <= '0;
      lane2_q     <= '0;
      lane3_q     <= '0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
    end else begin
      out_valid_q <= (state_q == S_READ);
      out_start_q <= (state_q == S_READ) && (k_q == '0);
      if (state_q == S_READ) begin
        lane0_q <= mem_q[rd_sel_q][0][k_q];
        lane1_q <= mem_q[rd_sel_q][2][k_q];
        lane2_q <= mem_q[rd_sel_q][1][k_q];
        lane3_q <= mem_q[rd_sel_q][3][k_q];
      end
    end
  end

  assign fftIn0_up   = lane0_q;
  assign fftIn0_down = lane1_q;
  assign fftIn1_up   = lane2_q;
  assign fftIn1_down = lane3_q;
  assign out_valid   = out_valid_q;
  assign out_start   = out_start_q;

endmodule
